// File: rtl/rr_src_arbiter_if.sv
// Handshake bundle between N val/rdy message sources, the round-robin
// arbiter and the single shared sink.
interface rr_src_arbiter_if #(
  parameter int unsigned p_num_reqs  = 4,
  parameter int unsigned p_msg_nbits = 32
);
  localparam int unsigned p_src_nbits = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;

  logic [p_num_reqs-1:0]             en;
  logic [p_num_reqs-1:0]             in_val;
  logic [p_num_reqs-1:0]             in_rdy;
  logic [p_num_reqs*p_msg_nbits-1:0] in_msg;
  logic [p_num_reqs-1:0]             in_done;
  logic                              out_val;
  logic                              out_rdy;
  logic [p_msg_nbits-1:0]            out_msg;
  logic [p_src_nbits-1:0]            out_src;
  logic                              all_done;

  // arbiter side
  modport master (
    input  en, in_val, in_msg, in_done, out_rdy,
    output in_rdy, out_val, out_msg, out_src, all_done
  );

  // source/sink environment side
  modport slave (
    output en, in_val, in_msg, in_done, out_rdy,
    input  in_rdy, out_val, out_msg, out_src, all_done
  );
endinterface

// File: rtl/rr_src_arbiter.sv
// Round-robin arbiter: shares one val/rdy sink among p_num_reqs sources,
// one whole message per grant, with a one-entry registered output stage
// that also records the originating source index.
module rr_src_arbiter #(
  parameter int unsigned p_num_reqs  = 4,
  parameter int unsigned p_msg_nbits = 32
) (
  input  logic             clk,
  input  logic             reset,   // active-low, asynchronous
  rr_src_arbiter_if.master bus
);
  localparam int unsigned p_src_nbits = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;

  logic [p_num_reqs-1:0]  elig;
  logic                   found;
  logic [p_src_nbits-1:0] winner;
  logic [p_src_nbits-1:0] ptr;
  logic [p_src_nbits-1:0] ptr_nxt;
  logic                   can_accept;
  logic                   xfer;
  logic [p_num_reqs-1:0]  in_rdy_c;
  int unsigned            pos;

  logic                   out_val_q;
  logic [p_msg_nbits-1:0] out_msg_q;
  logic [p_src_nbits-1:0] out_src_q;

  logic [p_msg_nbits-1:0] msg_arr [p_num_reqs];

  for (genvar g = 0; g < p_num_reqs; g++) begin : g_unpack
    assign msg_arr[g] = bus.in_msg[g*p_msg_nbits +: p_msg_nbits];
  end

  // Eligibility and output-stage availability
  always_comb begin
    elig       = bus.in_val & bus.en;
    can_accept = !out_val_q || bus.out_rdy;
  end

  // Rotating priority search starting at ptr; first eligible index wins
  always_comb begin
    found  = 1'b0;
    winner = '0;
    pos    = 0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= p_num_reqs) pos = pos - p_num_reqs;
      if (!found && elig[pos[p_src_nbits-1:0]]) begin
        found  = 1'b1;
        winner = pos[p_src_nbits-1:0];
      end
    end
  end

  // Grant decode: one-hot ready to the winner, gated off during reset
  always_comb begin
    xfer     = found && can_accept;
    in_rdy_c = '0;
    if (reset && xfer) in_rdy_c[winner] = 1'b1;
    ptr_nxt  = (winner == p_src_nbits'(p_num_reqs - 1)) ? '0 : winner + 1'b1;
  end

  // Output register and priority pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_src_q <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_val_q <= 1'b1;
      out_msg_q <= msg_arr[winner];
      out_src_q <= winner;
      ptr       <= ptr_nxt;
    end else if (bus.out_rdy) begin
      out_val_q <= 1'b0;
    end
  end

  assign bus.in_rdy   = in_rdy_c;
  assign bus.out_val  = out_val_q;
  assign bus.out_msg  = out_msg_q;
  assign bus.out_src  = out_src_q;
  assign bus.all_done = (&bus.in_done) && !out_val_q;

endmodule

// File: tb/tb_rr_src_arbiter.sv
// Bench for rr_src_arbiter: directed scenarios with literal expectations,
// a random phase and a random-delay completion run, all cross-checked every
// cycle against a behavioural model of the arbitration rules.
module tb_rr_src_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_src_arbiter_if #(.p_num_reqs(N), .p_msg_nbits(W)) bus ();

  rr_src_arbiter #(.p_num_reqs(N), .p_msg_nbits(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         m_val;
  logic [W-1:0] m_msg;
  int           m_src;
  int           m_ptr;
  int           mw;

  function automatic int pick(input int p, input logic [N-1:0] e);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (e[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    logic [N-1:0] r;
    int w;
    r = '0;
    if (reset !== 1'b1) return r;
    w = pick(m_ptr, bus.in_val & bus.en);
    if (w >= 0 && (!m_val || bus.out_rdy)) r[w] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_val = 1'b0;
      m_msg = '0;
      m_src = 0;
      m_ptr = 0;
    end else begin
      mw = pick(m_ptr, bus.in_val & bus.en);
      if (mw >= 0 && (!m_val || bus.out_rdy)) begin
        m_msg = bus.in_msg[mw*W +: W];
        m_src = mw;
        m_val = 1'b1;
        m_ptr = (mw + 1) % N;
      end else if (m_val && bus.out_rdy) begin
        m_val = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("in_rdy", bus.in_rdy, exp_rdy());
    check("out_val", bus.out_val, m_val);
    if (m_val) begin
      check("out_msg", bus.out_msg, m_msg);
      check("out_src", bus.out_src, m_src);
    end
    check("all_done", bus.all_done, (&bus.in_done) && !m_val);
  end

  // ---------------- helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int seq_a [6] = '{0, 1, 2, 3, 0, 1};
  int seq_b [4] = '{1, 3, 1, 3};
  int cnt [N];
  int dly [N];
  int nxt [N];
  int delivered;
  bit finished;
  logic [N-1:0] fi;
  logic fo, ad;
  logic [W-1:0] om;
  logic [1:0] os;
  int s;

  initial begin
    bus.en      = '1;
    bus.in_val  = '1;
    bus.in_msg  = '0;
    bus.in_done = '0;
    bus.out_rdy = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;

    // reset state, with requests pending
    cyc(); settle();
    check("rst_in_rdy", bus.in_rdy, 4'b0000);
    check("rst_out_val", bus.out_val, 1'b0);
    check("rst_out_msg", bus.out_msg, 32'h0);
    check("rst_out_src", bus.out_src, 2'd0);
    check("rst_all_done_lo", bus.all_done, 1'b0);
    bus.in_done = '1;
    settle();
    check("rst_all_done_hi", bus.all_done, 1'b1);
    bus.in_done = '0;
    bus.in_val  = '0;
    cyc();
    reset = 1'b1;

    // single requester
    cyc();
    bus.in_msg[2*W +: W] = 32'hA5;
    bus.in_val = 4'b0100;
    settle();
    check("single_in_rdy", bus.in_rdy, 4'b0100);
    cyc();
    bus.in_val = '0;
    settle();
    check("single_out_val", bus.out_val, 1'b1);
    check("single_out_msg", bus.out_msg, 32'hA5);
    check("single_out_src", bus.out_src, 2'd2);
    cyc(); settle();
    check("single_drained", bus.out_val, 1'b0);
    for (int i = 0; i < N; i++) bus.in_msg[i*W +: W] = 32'h10 + i;
    bus.in_val = '1;
    settle();
    check("ptr_after_single", bus.in_rdy, 4'b1000);

    // full contention after reset
    do_reset();
    settle();
    check("cont_first_rdy", bus.in_rdy, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      cyc(); settle();
      check("cont_out_val", bus.out_val, 1'b1);
      check("cont_out_src", bus.out_src, seq_a[k]);
      check("cont_out_msg", bus.out_msg, 32'h10 + seq_a[k]);
    end

    // back-pressure while holding 0x11
    bus.in_val  = 4'b1001;
    bus.out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("bp_in_rdy", bus.in_rdy, 4'b0000);
      check("bp_out_msg", bus.out_msg, 32'h11);
      cyc();
    end
    bus.out_rdy = 1'b1;
    settle();
    check("bp_release_rdy", bus.in_rdy, 4'b1000);
    cyc(); settle();
    check("bp_refill_msg", bus.out_msg, 32'h13);
    check("bp_refill_src", bus.out_src, 2'd3);

    // reset mid-operation, held output, ptr=2
    bus.in_val = 4'b0010;
    cyc(); settle();
    check("mid_src1", bus.out_src, 2'd1);
    bus.out_rdy = 1'b0;
    bus.in_val  = '1;
    cyc(); settle();
    check("mid_held", bus.out_val, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("mid_async_val", bus.out_val, 1'b0);
    check("mid_async_msg", bus.out_msg, 32'h0);
    check("mid_async_rdy", bus.in_rdy, 4'b0000);
    cyc();
    reset = 1'b1;
    bus.in_val  = 4'b0110;
    bus.out_rdy = 1'b1;
    settle();
    check("mid_post_rdy", bus.in_rdy, 4'b0010);
    cyc(); settle();
    check("mid_post_src", bus.out_src, 2'd1);

    // enable mask
    bus.in_val = '0;
    do_reset();
    bus.en     = 4'b1010;
    bus.in_val = '1;
    for (int k = 0; k < 4; k++) begin
      cyc(); settle();
      check("en_src", bus.out_src, seq_b[k]);
    end
    bus.en = 4'b0010;
    settle();
    check("en_clear_rdy", bus.in_rdy, 4'b0010);
    for (int k = 0; k < 2; k++) begin
      cyc(); settle();
      check("en_clear_src", bus.out_src, 2'd1);
    end

    // random phase, checked by the model
    for (int c = 0; c < 300; c++) begin
      cyc();
      bus.in_val  = 4'($urandom);
      bus.en      = 4'($urandom);
      bus.out_rdy = 1'($urandom);
      bus.in_done = 4'($urandom);
      for (int i = 0; i < N; i++) bus.in_msg[i*W +: W] = $urandom;
    end

    // completion: four random-delay sources, 8 messages each
    bus.in_val  = '0;
    bus.in_done = '0;
    bus.en      = '1;
    bus.out_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      nxt[i] = 0;
      dly[i] = $urandom_range(0, 3);
      bus.in_msg[i*W +: W] = i << 16;
    end
    delivered = 0;
    finished  = 1'b0;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      fi = bus.in_val & bus.in_rdy;
      fo = bus.out_val & bus.out_rdy;
      om = bus.out_msg;
      os = bus.out_src;
      ad = bus.all_done;
      if (ad) begin
        check("all_done_after_last", delivered, 32);
        finished = 1'b1;
      end
      if (fo) begin
        s = int'(om[31:16]);
        check("cmp_src_field", os, s);
        if (s < N) begin
          check("cmp_order", om[15:0], nxt[s]);
          nxt[s]++;
        end
        delivered++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fi[i]) begin
          cnt[i]++;
          bus.in_val[i] = 1'b0;
          dly[i] = $urandom_range(0, 3);
        end
        if (!bus.in_val[i] && cnt[i] < 8) begin
          if (dly[i] == 0) bus.in_val[i] = 1'b1;
          else dly[i]--;
        end
        bus.in_msg[i*W +: W] = (i << 16) | cnt[i];
        bus.in_done[i] = (cnt[i] == 8);
      end
      bus.out_rdy = ($urandom_range(0, 3) != 0);
    end
    check("completion_finished", finished, 1'b1);
    check("completion_count", delivered, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_src_arbiter.md
# rr_src_arbiter

Round-robin arbiter that shares one val/rdy sink among `p_num_reqs` val/rdy message sources. Typical use: several random-delay test sources feeding one DUT input port or one test sink. Message-granular arbitration: one whole message per grant, fair rotation, and a one-entry registered output stage. Also reports which source each output message came from, and when every source has finished and the output stage is empty.

## Interface
- `p_num_reqs`, 4: number of requesters, 1..16.
- `p_msg_nbits`, 32: message width.
- `p_src_nbits`, derived: max(1, $clog2(p_num_reqs)); not overridden.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low. Asserted when 0; released synchronously to `clk` by the environment.
- `en`  in  p_num_reqs  per-requester enable. A disabled requester is never granted.
- `in_val`  in  p_num_reqs  request valid, bit i = requester i.
- `in_rdy`  out  p_num_reqs  request ready; at most one bit high per cycle.
- `in_msg`  in  p_num_reqs*p_msg_nbits  flattened messages; requester i occupies bits [i*p_msg_nbits +: p_msg_nbits].
- `in_done`  in  p_num_reqs  per-requester done flag, from each source's `done` output.
- `out_val`  out  1  output message valid (registered).
- `out_rdy`  in  1  sink ready.
- `out_msg`  out  p_msg_nbits  output message (registered).
- `out_src`  out  p_src_nbits  index of the requester that supplied `out_msg` (registered).
- `all_done`  out  1  high when all `in_done` bits are 1 and `out_val` is 0.

## Operation
- State:
  - output register {`out_val`, `out_msg`, `out_src`};
  - priority pointer `ptr` (p_src_nbits wide), which names the highest-priority requester.
- `can_accept` = !out_val || out_rdy. The output stage is empty, or it drains this cycle.
- Eligible set: `E[i]` = in_val[i] & en[i].
- Winner: the first i with E[i] = 1, searching ptr, ptr+1, …, p_num_reqs-1, 0, …, ptr-1.
- `in_rdy[winner]` = can_accept when E is non-zero. All other `in_rdy` bits are 0.
  - `in_rdy` depends combinationally on `in_val`, `en`, `out_val` and `out_rdy`. Sources must not make `val` depend on `rdy`.
- On a transfer (E non-zero and can_accept):
  - `out_msg` <= in_msg of winner;
  - `out_src` <= winner;
  - `out_val` <= 1;
  - `ptr` <= winner+1, wrapping p_num_reqs-1 → 0.
- If no transfer happens and out_rdy && out_val: `out_val` <= 0; `ptr` is unchanged.
- If no transfer happens and the output is held (out_val && !out_rdy): all registers hold. `out_msg` and `out_src` stay stable while out_val=1 and out_rdy=0.
- Pointer movement: `ptr` advances only on a grant, never on idle cycles. A requester that loses keeps its position relative to the pointer.
- Starvation bound: a continuously valid, enabled requester is granted within p_num_reqs grants.
- `en` changes take effect the same cycle. Clearing `en[i]` never cancels a message already in the output register.
- With p_num_reqs = 1: `ptr` stays 0, `out_src` = 0, and the block behaves as a one-entry pipe register.
- Reset (asynchronous, at any time, including mid-transfer):
  - `out_val` = 0, `out_msg` = 0, `out_src` = 0, `ptr` = 0;
  - all `in_rdy` = 0 while reset is asserted;
  - a held message is discarded.

## Timing
- Latency: 1 cycle from the input handshake to `out_val`.
- Throughput: 1 message per cycle when `out_rdy` stays high. A drain and a refill happen in the same cycle.
- Back-pressure: with out_val=1 and out_rdy=0, no `in_rdy` is asserted.
- `all_done` is combinational from `in_done` and registered `out_val`. It is 0 during reset only if some `in_done` is 0.
- First cycle after reset release: `in_rdy` may assert immediately, because the output is empty.

## Test plan
- Single requester: N=4, only in_val[2]=1 with msg 0xA5, out_rdy=1.
  - Required: in_rdy=4'b0100 in cycle 0; in cycle 1 out_val=1, out_msg=0xA5, out_src=2; ptr=3.
- Full contention: all four valid every cycle, msgs 0x10+i, out_rdy=1, after reset.
  - Required: out_src sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Back-pressure: out_rdy=0 for 3 cycles while the output holds 0x11 and requesters 0 and 3 are valid.
  - Required: in_rdy=0 throughout and out_msg held at 0x11.
  - When out_rdy rises: 0x11 drains and the next winner loads in the same cycle.
- Enable mask: en=4'b1010, all valid.
  - Required: only sources 1 and 3 are granted, alternating 1,3,1,3.
  - Clearing en[3] mid-stream stops source 3 from the next cycle on.
- Reset mid-operation: assert reset while out_val=1 and out_rdy=0, with ptr=2.
  - Required: out_val=0 asynchronously, before the next edge.
  - After release, the first grant goes to the lowest-index valid requester (ptr=0).
- Completion: four random-delay sources with 8 messages each and random out_rdy.
  - Required: 32 messages delivered, per-source order preserved, out_src matches each message's origin.
  - all_done rises only after the final message's handshake.
